// File: rtl/bch_correct_buffer.sv
// bch_correct_buffer: holds received data chunks and XORs them with the Chien error stream.
// Optional BCH_CORRECT_COUNT_EN adds flip_count, the number of bits corrected per codeword.
module bch_correct_buffer #(
   parameter int DATA_BITS = 5,
   parameter int ECC_BITS  = 10,
   parameter int BITS      = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_start,
   input  logic            in_valid,
   input  logic [BITS-1:0] in_data,
   output logic            in_ready,
   input  logic            err_first,
   input  logic            err_valid,
   input  logic [BITS-1:0] err,
   output logic            out_valid,
   output logic [BITS-1:0] out_data,
   output logic            out_first,
   output logic            out_last,
   output logic            seq_err
`ifdef BCH_CORRECT_COUNT_EN
   ,
   output logic [$clog2(DATA_BITS+1)-1:0] flip_count
`endif
);
   localparam int DC = DATA_BITS / BITS;
   localparam int CC = (DATA_BITS + ECC_BITS) / BITS;
   localparam int CW = $clog2(CC + 1);
   localparam int IW = DC > 1 ? $clog2(DC) : 1;
   localparam logic [CW-1:0] DC_N  = CW'(DC);
   localparam logic [CW-1:0] DC_M1 = CW'(DC - 1);
   localparam logic [CW-1:0] CC_M1 = CW'(CC - 1);
   localparam logic [CW-1:0] ONE   = CW'(1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_ERR, CORRECT} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [BITS-1:0] r_buf [DC];
   logic            w_acc, w_fire, w_step, w_wr;
   logic [IW-1:0]   w_wr_idx, w_rd_idx;
   logic            w_valid_nxt, w_first_nxt, w_last_nxt, w_seq_nxt;
   logic [BITS-1:0] w_data_nxt;

   assign in_ready = (r_state == IDLE) || (r_state == LOAD);
   assign w_acc    = in_valid & in_ready;
   assign w_fire   = err_first & ((r_state == WAIT_ERR) || (r_state == CORRECT));
   assign w_step   = err_valid & ~err_first & (r_state == CORRECT);
   // ECC chunks only advance the counter; they are never stored
   assign w_wr     = w_acc & (in_start | ((r_state == LOAD) & (r_cnt < DC_N)));
   assign w_wr_idx = in_start ? '0 : r_cnt[IW-1:0];
   assign w_rd_idx = err_first ? '0 : r_cnt[IW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         seq_err   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         out_valid <= w_valid_nxt;
         out_first <= w_first_nxt;
         out_last  <= w_last_nxt;
         out_data  <= w_data_nxt;
         seq_err   <= w_seq_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_buf[w_wr_idx] <= in_data;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_acc && in_start) begin
               w_state_nxt = LOAD;
               w_cnt_nxt   = ONE;
            end
         end
         LOAD: begin
            if (w_acc) begin
               w_state_nxt = (!in_start && r_cnt == CC_M1) ? WAIT_ERR : LOAD;
               w_cnt_nxt   = in_start ? ONE : (r_cnt == CC_M1) ? '0 : r_cnt + ONE;
            end
         end
         default: begin
            if (w_fire) begin
               w_state_nxt = (DC == 1) ? IDLE : CORRECT;
               w_cnt_nxt   = (DC == 1) ? '0 : ONE;
            end else if (w_step) begin
               w_state_nxt = (r_cnt == DC_M1) ? IDLE : CORRECT;
               w_cnt_nxt   = (r_cnt == DC_M1) ? '0 : r_cnt + ONE;
            end
         end
      endcase
   end

   always_comb begin
      w_valid_nxt = w_fire | w_step;
      w_first_nxt = w_fire;
      w_last_nxt  = w_fire ? (DC == 1) : (w_step & (r_cnt == DC_M1));
      w_data_nxt  = w_valid_nxt ? (r_buf[w_rd_idx] ^ err) : out_data;
      w_seq_nxt   = seq_err | (w_acc & (in_start == (r_state == LOAD)))
                  | (err_first & (r_state == CORRECT));
   end

`ifdef BCH_CORRECT_COUNT_EN
   localparam int FW = $clog2(DATA_BITS + 1);
   logic [FW-1:0] w_pop;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < BITS; i++) w_pop = w_pop + FW'(err[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) flip_count <= '0;
      else if (w_fire) flip_count <= w_pop;
      else if (w_step) flip_count <= flip_count + w_pop;
   end
`endif
endmodule

// File: tb/tb_bch_correct_buffer.sv
// tb_bch_correct_buffer: scoreboard bench for BITS=1 (5 data chunks) and BITS=5 (single data chunk).
module tb_bch_correct_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic in_start = 1'b0, in_valid = 1'b0, in_data = 1'b0, in_ready;
   logic err_first = 1'b0, err_valid = 1'b0, err = 1'b0;
   logic out_valid, out_data, out_first, out_last, seq_err;
   logic b_in_start = 1'b0, b_in_valid = 1'b0, b_in_ready;
   logic [4:0] b_in_data = '0, b_err = '0, b_out_data;
   logic b_err_first = 1'b0, b_err_valid = 1'b0;
   logic b_out_valid, b_out_first, b_out_last, b_seq_err;
`ifdef BCH_CORRECT_COUNT_EN
   logic [2:0] flip_count, b_flip_count;
`endif

   bch_correct_buffer #(.DATA_BITS(5), .ECC_BITS(10), .BITS(1)) u_dut (
      .clk(clk), .rst(rst), .in_start(in_start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .err_first(err_first), .err_valid(err_valid), .err(err),
      .out_valid(out_valid), .out_data(out_data), .out_first(out_first), .out_last(out_last),
      .seq_err(seq_err)
`ifdef BCH_CORRECT_COUNT_EN
      , .flip_count(flip_count)
`endif
   );

   bch_correct_buffer #(.DATA_BITS(5), .ECC_BITS(10), .BITS(5)) u_dut5 (
      .clk(clk), .rst(rst), .in_start(b_in_start), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_ready(b_in_ready), .err_first(b_err_first), .err_valid(b_err_valid), .err(b_err),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_first(b_out_first), .out_last(b_out_last),
      .seq_err(b_seq_err)
`ifdef BCH_CORRECT_COUNT_EN
      , .flip_count(b_flip_count)
`endif
   );

   typedef struct {logic d; logic f; logic l; int c; int fc;} exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected got data=%0b first=%0b last=%0b cycle=%0d, required no output", out_data, out_first, out_last, cyc);
         end else begin
            e = sb.pop_front();
            if ({out_data, out_first, out_last} !== {e.d, e.f, e.l} || cyc != e.c) begin
               failures++;
               $display("FAIL out_chunk got data=%0b first=%0b last=%0b cycle=%0d, required data=%0b first=%0b last=%0b cycle=%0d",
                        out_data, out_first, out_last, cyc, e.d, e.f, e.l, e.c);
            end
`ifdef BCH_CORRECT_COUNT_EN
            if (e.l) begin
               checks++;
               if (flip_count !== 3'(e.fc)) begin
                  failures++;
                  $display("FAIL flip_count got %0d, required %0d", flip_count, e.fc);
               end
            end
`endif
         end
      end else if (out_first || out_last) begin
         checks++;
         failures++;
         $display("FAIL framing_without_valid got first=%0b last=%0b, required 0 0", out_first, out_last);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cw(input logic [14:0] cw, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_start = (i == 0);
         in_data  = cw[i];
         tick();
      end
      in_valid = 1'b0;
      in_start = 1'b0;
   endtask

   task automatic send_err(input logic [4:0] d, input logic [4:0] m, input int gap);
      int fc = 0;
      for (int k = 0; k < 5; k++) begin
         fc = (k == 0) ? int'(m[0]) : fc + int'(m[k]);
         sb.push_back('{d: d[k] ^ m[k], f: (k == 0), l: (k == 4), c: cyc + 1, fc: fc});
         err_first = (k == 0);
         err_valid = (k != 0);
         err       = m[k];
         tick();
         err_first = 1'b0;
         err_valid = 1'b0;
         err       = 1'b0;
         repeat (gap) tick();
      end
      repeat (2) tick();
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, out_first, out_last, out_data, seq_err} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_state got ready=%0b valid=%0b first=%0b last=%0b data=%0b seq=%0b, required 1 0 0 0 0 0",
                  in_ready, out_valid, out_first, out_last, out_data, seq_err);
      end
      checks++;
      if ({b_in_ready, b_out_valid, b_out_data, b_seq_err} !== {1'b1, 1'b0, 5'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state5 got ready=%0b valid=%0b data=%0h seq=%0b, required 1 0 0 0",
                  b_in_ready, b_out_valid, b_out_data, b_seq_err);
      end
`ifdef BCH_CORRECT_COUNT_EN
      checks++;
      if (flip_count !== 3'd0) begin
         failures++;
         $display("FAIL reset_flip_count got %0d, required 0", flip_count);
      end
`endif
   endtask

   task automatic test_clean();
      logic [14:0] cw = {10'($urandom()), 5'b00011};
      load_cw(cw, 15);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_after_load got %0b, required 0", in_ready);
      end
      send_err(cw[4:0], 5'b00000, 0);
      err_valid = 1'b1;
      tick();
      err_valid = 1'b0;
      repeat (2) tick();
      checks++;
      if (sb.size() != 0 || in_ready !== 1'b1 || seq_err !== 1'b0) begin
         failures++;
         $display("FAIL clean_done got pending=%0d ready=%0b seq=%0b, required 0 1 0", sb.size(), in_ready, seq_err);
      end
   endtask

   task automatic test_errors();
      logic [14:0] cw = {10'($urandom()), 5'b00011};
      load_cw(cw, 15);
      send_err(cw[4:0], 5'b10010, 0);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL errors_drain got pending=%0d, required 0", sb.size());
      end
   endtask

   task automatic test_gaps();
      for (int r = 0; r < 3; r++) begin
         logic [14:0] cw = 15'($urandom());
         load_cw(cw, 15);
         send_err(cw[4:0], 5'($urandom()), 3);
         checks++;
         if (sb.size() != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL gaps_drain got pending=%0d ready=%0b, required 0 1", sb.size(), in_ready);
         end
      end
   endtask

   task automatic test_wait_hold();
      logic [14:0] cw = 15'($urandom());
      load_cw(cw, 15);
      for (int i = 0; i < 20; i++) begin
         err_valid = (i % 3 == 0);
         err       = 1'b1;
         tick();
      end
      err_valid = 1'b0;
      err       = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL wait_hold got ready=%0b pending=%0d, required 0 0", in_ready, sb.size());
      end
      send_err(cw[4:0], 5'b01100, 1);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL wait_drain got pending=%0d, required 0", sb.size());
      end
   endtask

   task automatic test_mid_reset();
      logic [14:0] cw = 15'($urandom());
      load_cw(15'h7fff, 7);
      pulse_rst();
      checks++;
      if ({in_ready, out_valid, seq_err} !== 3'b100) begin
         failures++;
         $display("FAIL mid_reset got ready=%0b valid=%0b seq=%0b, required 1 0 0", in_ready, out_valid, seq_err);
      end
      load_cw(cw, 15);
      send_err(cw[4:0], 5'b00001, 0);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL mid_reset_drain got pending=%0d, required 0", sb.size());
      end
   endtask

   task automatic test_seq_err();
      logic [14:0] cw = 15'($urandom());
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (seq_err !== 1'b1) begin
         failures++;
         $display("FAIL seq_err_idle got %0b, required 1", seq_err);
      end
      repeat (3) tick();
      for (int i = 0; i < 15; i++) begin
         in_valid  = 1'b1;
         in_start  = (i == 0);
         in_data   = cw[i];
         err_first = (i == 5 || i == 9);
         err       = 1'b1;
         tick();
      end
      {in_valid, in_start, err_first, err} = 4'b0;
      send_err(cw[4:0], 5'b00110, 0);
      checks++;
      if (seq_err !== 1'b1 || sb.size() != 0) begin
         failures++;
         $display("FAIL seq_err_sticky got seq=%0b pending=%0d, required 1 0", seq_err, sb.size());
      end
   endtask

   task automatic test_restart();
      logic [14:0] cw = 15'($urandom());
      pulse_rst();
      load_cw(15'h5555, 4);
      load_cw(cw, 15);
      checks++;
      if (seq_err !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL load_restart got seq=%0b ready=%0b, required 1 0", seq_err, in_ready);
      end
      send_err(cw[4:0], 5'b00000, 0);
      pulse_rst();
      load_cw(cw, 15);
      for (int k = 0; k < 3; k++) begin
         sb.push_back('{d: cw[k], f: (k == 0), l: 1'b0, c: cyc + 1, fc: 0});
         err_first = (k == 0);
         err_valid = (k != 0);
         tick();
      end
      {err_first, err_valid} = 2'b0;
      tick();
      send_err(cw[4:0], 5'b11000, 0);
      checks++;
      if (seq_err !== 1'b1 || sb.size() != 0) begin
         failures++;
         $display("FAIL correct_restart got seq=%0b pending=%0d, required 1 0", seq_err, sb.size());
      end
   endtask

   task automatic test_dc1();
      logic [4:0] d = 5'($urandom());
      for (int i = 0; i < 3; i++) begin
         b_in_valid = 1'b1;
         b_in_start = (i == 0);
         b_in_data  = (i == 0) ? d : 5'($urandom());
         tick();
      end
      {b_in_valid, b_in_start} = 2'b0;
      checks++;
      if (b_in_ready !== 1'b0) begin
         failures++;
         $display("FAIL dc1_ready got %0b, required 0", b_in_ready);
      end
      b_err_first = 1'b1;
      b_err       = 5'b00100;
      tick();
      b_err_first = 1'b0;
      b_err       = 5'b0;
      checks++;
      if ({b_out_valid, b_out_first, b_out_last, b_out_data} !== {3'b111, d ^ 5'b00100}) begin
         failures++;
         $display("FAIL dc1_out got valid=%0b first=%0b last=%0b data=%0h, required 1 1 1 %0h",
                  b_out_valid, b_out_first, b_out_last, b_out_data, d ^ 5'b00100);
      end
`ifdef BCH_CORRECT_COUNT_EN
      checks++;
      if (b_flip_count !== 3'd1) begin
         failures++;
         $display("FAIL dc1_flip_count got %0d, required 1", b_flip_count);
      end
`endif
      b_err_valid = 1'b1;
      tick();
      b_err_valid = 1'b0;
      checks++;
      if ({b_out_valid, b_out_first, b_out_last, b_in_ready, b_seq_err} !== 5'b00010) begin
         failures++;
         $display("FAIL dc1_after got valid=%0b first=%0b last=%0b ready=%0b seq=%0b, required 0 0 0 1 0",
                  b_out_valid, b_out_first, b_out_last, b_in_ready, b_seq_err);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_errors();
      test_gaps();
      test_wait_hold();
      test_mid_reset();
      test_dc1();
      test_seq_err();
      test_restart();
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bch_correct_buffer.md
Name: bch_correct_buffer

Overview:
- Receive-side companion to bch_encode.
- Captures a received codeword chunk-serially, keeps only the data chunks, and holds them while bch_syndrome, bch_sigma_bma_serial and bch_error_tmec/bch_error_one process the codeword.
- XORs each stored data chunk with the matching Chien error chunk.
- Emits the corrected data stream with first/last framing.

Parameters:
- DATA_BITS, 5: message bits per codeword; must be a multiple of BITS.
- ECC_BITS, 10: parity bits per codeword; must be a multiple of BITS.
- BITS, 1: chunk width, the same value as the encoder/syndrome/Chien BITS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_start  in  1  qualifies the first chunk of a codeword.
- in_valid  in  1  in_data holds a valid chunk.
- in_data  in  BITS  received codeword chunk, in transmission order.
- in_ready  out  1  block can accept a chunk.
- err_first  in  1  first Chien error chunk (bch_error_* first).
- err_valid  in  1  subsequent Chien error chunk (bch_chien_counter valid).
- err  in  BITS  error mask chunk.
- out_valid  out  1  out_data valid.
- out_data  out  BITS  corrected data chunk.
- out_first  out  1  first corrected chunk.
- out_last  out  1  final corrected chunk.
- seq_err  out  1  sticky protocol-violation flag.

Behaviour:
Derived values:
- DC = DATA_BITS/BITS
- CC = (DATA_BITS+ECC_BITS)/BITS
- Chunk counter width = $clog2(CC+1).

Reset (rst=1 at posedge, from any state including mid-codeword):
- state=IDLE, in_ready=1, out_valid=0, out_first=0, out_last=0, out_data=0, seq_err=0, counter=0.
- Buffer contents are don't-care.

States:
- IDLE
  - in_ready=1.
  - A chunk is accepted when in_valid & in_ready.
  - An accepted chunk with in_start: store in slot 0, counter=1, go to LOAD.
  - An accepted chunk without in_start: ignore it and set seq_err.
- LOAD
  - in_ready=1.
  - Each accepted chunk: if counter<DC, store in slot counter; otherwise discard (ECC chunk). Then counter++.
  - When the chunk that makes counter==CC is accepted: go to WAIT_ERR and reset counter to 0. in_ready drops the following cycle.
  - in_start on an accepted chunk in LOAD: set seq_err, restart as slot 0 (counter=1).
  - Gaps with in_valid=0 are allowed.
- WAIT_ERR
  - in_ready=0.
  - On err_first: out_data = slot0 ^ err, out_valid=1, out_first=1, counter=1, go to CORRECT.
  - err_valid without err_first: ignored.
  - Codeword data stays held indefinitely.
- CORRECT
  - in_ready=0.
  - Each err_valid cycle: out_data = slot[counter] ^ err, out_valid=1, counter++.
  - out_last=1 on the chunk where counter==DC-1, then go to IDLE.
  - Cycles without err_valid: out_valid=0, counter holds.
  - err_first in CORRECT: set seq_err and restart output at slot 0 with out_first=1.
  - DC==1: the err_first chunk carries out_first=1 and out_last=1, then go to IDLE.

Timing:
- All outputs are registered: out_* appears exactly 1 cycle after the err_first/err_valid edge that produced it.
- out_first and out_last are single-cycle pulses, asserted only together with out_valid.
- Chunk k of the error stream corrects the k-th data chunk received.
- Error chunks arriving after DC outputs are ignored.
- No backpressure on the output: the Chien stream cannot stall, so no out_ready.
- seq_err is cleared only by rst.

Optional Feature:
BCH_CORRECT_COUNT_EN
- When defined:
  - Adds output flip_count, width $clog2(DATA_BITS+1).
  - A running sum of popcount(err) over the corrected data chunks.
  - Cleared on err_first (then loaded with that chunk's popcount).
  - Final value is valid in the out_last cycle and held until the next err_first or rst.
  - Reset value is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (DATA_BITS=5, ECC_BITS=10, BITS=1 unless noted):
- Load 15-bit codeword, data chunks 1,1,0,0,0, in_valid continuous from in_start → in_ready=0 the cycle after chunk 15. Then err_first with err=0 and 4 err_valid all 0 → out 1,1,0,0,0; out_first on cycle 1, out_last on cycle 5, each 1 cycle after its err edge.
- Same codeword, error masks 0,1,0,0,1 → out 1,0,0,0,1; flip_count=2 at out_last (with BCH_CORRECT_COUNT_EN).
- err_valid gaps of 3 idle cycles between chunks → out_valid only on err cycles, data order unchanged, out_last on the 5th output.
- rst pulsed after chunk 7 of loading → next cycle in_ready=1, out_valid=0, seq_err=0. A fresh codeword then decodes correctly.
- in_valid chunk without in_start in IDLE → seq_err=1 and sticky. err_first arriving during LOAD is ignored.
- BITS=5, DATA_BITS=5, ECC_BITS=10 (3 chunks): err_first with err=5'b00100 → a single output with out_first=out_last=1, data bit 2 inverted.
